pmem_burst_adaptor: RTL and testbench
=====================================

# pmem_burst_adaptor

Memory-side responder for the cache's physical-memory line interface. Accepts a 256-bit line read or write from the cache datapath/control (`pmem_*` signals) and converts it into a four-beat 64-bit burst transaction on the main-memory port. It returns a single-cycle completion strobe to the cache. It sits between the cache and the burst memory model or DRAM controller, one instance per cache.

## Interface
Parameters:
- `s_line`, 256, cache line width in bits.
- `s_burst`, 64, memory beat width; `s_line` must be an integer multiple.
- `s_beats`, `s_line/s_burst` (4), beats per line; derived, not overridden.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pmem_address`  in  32  line address from the cache.
- `pmem_read`  in  1  line read request, held until `pmem_resp`.
- `pmem_write`  in  1  line write request, held until `pmem_resp`.
- `pmem_wdata`  in  256  line to write; stable while `pmem_write` is high.
- `pmem_rdata`  out  256  assembled read line.
- `pmem_resp`  out  1  one-cycle completion strobe.
- `mem_address`  out  32  burst base address.
- `mem_read`  out  1  burst read request.
- `mem_write`  out  1  burst write request.
- `mem_wdata`  out  64  current write beat.
- `mem_rdata`  in  64  current read beat.
- `mem_resp`  in  1  per-beat acknowledge from memory.

## Operation
- The FSM has 5 states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- **IDLE:** requests are sampled only in this state.
  - If `pmem_write`=1, go to WR_BURST. Write has priority if both requests are high.
  - Else if `pmem_read`=1, go to RD_BURST.
  - On either transition, latch `{pmem_address[31:5],5'b0}` into the address register and `pmem_wdata` into the line buffer. Clear the beat counter to 0.
- **RD_BURST:**
  - `mem_read`=1.
  - On each `mem_resp`=1, store `mem_rdata` into line-buffer bits [64k+63:64k], where k is the beat counter, then increment k.
  - When `mem_resp` arrives at k=`s_beats`-1, go to RD_DONE.
- **RD_DONE:**
  - `pmem_resp`=1 for exactly one cycle.
  - `pmem_rdata` presents the line buffer.
  - Next state is IDLE.
- **WR_BURST:**
  - `mem_write`=1 and `mem_wdata` = line-buffer bits [64k+63:64k].
  - On each `mem_resp`, increment k.
  - On the last `mem_resp`, go to WR_DONE.
- **WR_DONE:** `pmem_resp`=1 for one cycle, then IDLE.
- `mem_address` presents the latched, 32-byte-aligned address while any burst is active, and holds its last value otherwise.
- `pmem_rdata` holds the last completed read line until the next read completes. A write never alters it.
- The beat counter is `$clog2(s_beats)` bits and resets to 0 at every burst start.
- `mem_resp` is ignored in IDLE, RD_DONE and WR_DONE.
- Request inputs are ignored outside IDLE, so a new or changed address mid-burst has no effect.
- Gaps between beats are legal: the counter advances only on `mem_resp`.

## Timing
- Reset values:
  - all outputs 0, including `pmem_rdata`=0 and `mem_address`=0;
  - state IDLE, counter 0.
- Reset asserted mid-burst aborts the transaction immediately and asynchronously: `mem_read` and `mem_write` drop and no `pmem_resp` is issued.
- Cycle 0: request sampled in IDLE.
- Cycle 1: `mem_read` or `mem_write` high.
- With back-to-back `mem_resp` on cycles 1–4, `pmem_resp` is high on cycle 5.
- Minimum request-to-response latency is therefore 5 cycles.
- The cache must drop its request on the edge that ends the `pmem_resp` cycle. A request still high in the following IDLE cycle is treated as a new transaction.
- A new request can be accepted in the IDLE cycle right after RD_DONE or WR_DONE, giving a turnaround of one idle cycle.
- All outputs are driven from registers or state decode; there is no combinational path from any input to any output.

## Configuration
- Macro: `PMEM_ADAPTOR_PERF_CNT_EN`.
- **Defined:** adds output ports `perf_reads` [31:0] and `perf_writes` [31:0].
  - Each counter increments once per completed transaction, in its RD_DONE or WR_DONE cycle.
  - Counters wrap modulo 2^32, reset to 0, and are not cleared by aborted bursts.
- **Undefined:** the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- **Read, back-to-back beats.** `pmem_read` to 0x1234_5678. Memory returns beats 0x00..00AA, 0xBB, 0xCC, 0xDD on consecutive `mem_resp`.
  - Expect `mem_address`=0x1234_5660.
  - Expect `pmem_resp` on cycle 5 with `pmem_rdata`={0xDD,0xCC,0xBB,0xAA}, each beat zero-extended to 64 bits.
- **Write with stalls.** `pmem_write` with line {64'h4,64'h3,64'h2,64'h1}, and `mem_resp` only every third cycle.
  - Expect `mem_wdata` sequence 1,2,3,4, each held until its resp.
  - Expect a single `pmem_resp` after the 4th resp, and `pmem_rdata` unchanged.
- **Simultaneous requests.** `pmem_read` and `pmem_write` asserted together → write burst runs first.
- **Stray acknowledges.** `mem_resp` pulsed in IDLE → no state change and no `pmem_resp`.
- **Reset mid-read.** `rst` low after beat 2 of a read → outputs 0 immediately.
  - A subsequent read to 0x40 must complete normally with fresh beat ordering starting at beat 0.
- **Back-to-back transactions.** Write then read with `PMEM_ADAPTOR_PERF_CNT_EN` defined.
  - Expect exactly one idle cycle between the bursts.
  - Expect `perf_writes`=1 and `perf_reads`=1 at the end.

Source files
------------

// File: rtl/pmem_burst_adaptor_if.sv
// Signal bundle between the cache line port, pmem_burst_adaptor and the burst memory port.
// slave: the adaptor's view; master: the surrounding cache + memory environment.
interface pmem_burst_adaptor_if #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) ();
    logic [31:0]        pmem_address;
    logic               pmem_read;
    logic               pmem_write;
    logic [s_line-1:0]  pmem_wdata;
    logic [s_line-1:0]  pmem_rdata;
    logic               pmem_resp;

    logic [31:0]        mem_address;
    logic               mem_read;
    logic               mem_write;
    logic [s_burst-1:0] mem_wdata;
    logic [s_burst-1:0] mem_rdata;
    logic               mem_resp;

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// Converts one cache-line read/write into an s_beats-beat burst on the memory port.
// Optional performance counters are enabled by defining PMEM_ADAPTOR_PERF_CNT_EN.
module pmem_burst_adaptor #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) (
    input  logic clk,
    input  logic rst,
    pmem_burst_adaptor_if.slave bus
`ifdef PMEM_ADAPTOR_PERF_CNT_EN
    ,
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes
`endif
);
    localparam int unsigned s_beats = s_line / s_burst;
    localparam int unsigned cnt_w   = (s_beats > 1) ? $clog2(s_beats) : 1;
    localparam int unsigned addr_w  = 32;
    localparam int unsigned off_w   = $clog2(s_line / 8);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(s_beats - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_e;

    state_e                          state_q;
    state_e                          state_d;
    logic [cnt_w-1:0]                beat_q;
    logic [s_beats-1:0][s_burst-1:0] line_q;
    logic [s_beats-1:0][s_burst-1:0] rd_line;
    logic                            accept;
    logic                            beat_ack;

    // Byte offset within the line is dropped by alignment.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^bus.pmem_address[off_w-1:0];

    // Next-state decode; requests sampled only in IDLE, acknowledges only inside a burst.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        beat_ack         = 1'b0;
        rd_line          = line_q;
        rd_line[beat_q]  = bus.mem_rdata;
        unique case (state_q)
            IDLE: begin
                if (bus.pmem_write) begin
                    state_d = WR_BURST;
                    accept  = 1'b1;
                end else if (bus.pmem_read) begin
                    state_d = RD_BURST;
                    accept  = 1'b1;
                end
            end
            RD_BURST: begin
                if (bus.mem_resp) begin
                    beat_ack = 1'b1;
                    if (beat_q == last_beat) state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_BURST: begin
                if (bus.mem_resp) begin
                    beat_ack = 1'b1;
                    if (beat_q == last_beat) state_d = WR_DONE;
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Registered outputs track the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q          <= '0;
            line_q          <= '0;
            bus.mem_address <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_wdata   <= '0;
            bus.pmem_rdata  <= '0;
            bus.pmem_resp   <= 1'b0;
        end else begin
            bus.mem_read  <= (state_d == RD_BURST);
            bus.mem_write <= (state_d == WR_BURST);
            bus.pmem_resp <= (state_d == RD_DONE) || (state_d == WR_DONE);
            if (accept) begin
                beat_q          <= '0;
                line_q          <= bus.pmem_wdata;
                bus.mem_address <= {bus.pmem_address[addr_w-1:off_w], off_w'(0)};
                if (state_d == WR_BURST) bus.mem_wdata <= bus.pmem_wdata[s_burst-1:0];
            end else if (beat_ack) begin
                beat_q <= beat_q + cnt_w'(1);
                if (state_q == RD_BURST) begin
                    line_q[beat_q] <= bus.mem_rdata;
                    if (beat_q == last_beat) bus.pmem_rdata <= rd_line;
                end else begin
                    bus.mem_wdata <= line_q[beat_q + cnt_w'(1)];
                end
            end
        end
    end

`ifdef PMEM_ADAPTOR_PERF_CNT_EN
    // Completed-transaction counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_reads  <= '0;
            perf_writes <= '0;
        end else begin
            if (state_q == RD_DONE) perf_reads  <= perf_reads + 32'd1;
            if (state_q == WR_DONE) perf_writes <= perf_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: cache driver, burst-memory responder and a
// response monitor, checked against a word-addressed reference memory.
module tb_pmem_burst_adaptor;
    localparam int unsigned s_line  = 256;
    localparam int unsigned s_burst = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tick = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    pmem_burst_adaptor_if #(.s_line(s_line), .s_burst(s_burst)) bus ();

`ifdef PMEM_ADAPTOR_PERF_CNT_EN
    logic [31:0] perf_reads;
    logic [31:0] perf_writes;
`endif

    pmem_burst_adaptor #(.s_line(s_line), .s_burst(s_burst)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef PMEM_ADAPTOR_PERF_CNT_EN
        ,
        .perf_reads(perf_reads),
        .perf_writes(perf_writes)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [63:0] wdata;
    } beat_t;

    logic [63:0]  ref_mem  [logic [31:0]];
    logic [63:0]  resp_mem [logic [31:0]];
    logic [255:0] exp_q [$];
    beat_t        beat_q [$];
    logic [255:0] last_rd = '0;
    logic [255:0] held_rd = '0;
    int           n_rd = 0;
    int           n_wr = 0;
    int           resp_pct = 100;
    int           resp_period = 0;
    int           stray_pct = 0;
    int           resp_beat = 0;
    int           cyc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = ref_rd(a + 32'(8 * k));
        return l;
    endfunction

    // Burst memory model: checks every active burst cycle against the expected beat.
    initial begin
        beat_t b;
        logic  go;
        logic [31:0] ba;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 64'({$urandom, $urandom});
            if (bus.mem_read || bus.mem_write) begin
                check("beat_expected", 256'(beat_q.size() != 0), 256'(1));
                if (beat_q.size() != 0) begin
                    b = beat_q[0];
                    check("mem_address", 256'(bus.mem_address), 256'(b.addr));
                    check("mem_write", 256'(bus.mem_write), 256'(b.wr));
                    check("mem_read", 256'(bus.mem_read), 256'(!b.wr));
                    if (b.wr) check("mem_wdata", 256'(bus.mem_wdata), 256'(b.wdata));
                    go = (resp_period != 0) ? (cyc % resp_period == 0)
                                            : ($urandom_range(1, 100) <= resp_pct);
                    if (go) begin
                        ba = bus.mem_address + 32'(8 * resp_beat);
                        bus.mem_resp = 1'b1;
                        if (b.wr) resp_mem[ba] = bus.mem_wdata;
                        else bus.mem_rdata = resp_mem.exists(ba) ? resp_mem[ba] : fill(ba);
                        void'(beat_q.pop_front());
                        resp_beat = (resp_beat + 1) % 4;
                    end
                end
            end else if ($urandom_range(1, 100) <= stray_pct) begin
                bus.mem_resp = 1'b1;
            end
        end
    end

    // Response monitor: every pmem_resp consumes one expectation; rdata must hold otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.pmem_resp === 1'b1) begin
                check("pmem_resp_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    held_rd = exp_q.pop_front();
                    check("pmem_rdata", bus.pmem_rdata, held_rd);
                end
            end else begin
                check("pmem_rdata_hold", bus.pmem_rdata, held_rd);
            end
        end
    end

    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [255:0] wdata, input bit chk_lat,
                          output int resp_t, output int start_t);
        logic [31:0] a;
        beat_t       b;
        int          waited;
        int          first;
        bit          got;
        a = {addr[31:5], 5'b0};
        for (int k = 0; k < 4; k++) begin
            b.addr  = a;
            b.wr    = wr;
            b.wdata = wr ? wdata[k*64 +: 64] : 64'h0;
            beat_q.push_back(b);
            if (wr) ref_mem[a + 32'(8 * k)] = wdata[k*64 +: 64];
        end
        if (wr) begin
            exp_q.push_back(last_rd);
            n_wr++;
        end else begin
            last_rd = ref_line(a);
            exp_q.push_back(last_rd);
            n_rd++;
        end
        bus.pmem_address = addr;
        bus.pmem_wdata   = wdata;
        bus.pmem_write   = wr;
        bus.pmem_read    = rd;
        waited = 0;
        first  = -1;
        got    = 1'b0;
        start_t = -1;
        resp_t  = -1;
        while (!got && waited < 400) begin
            @(posedge clk); #1;
            waited++;
            if (first < 0 && (bus.mem_read || bus.mem_write)) begin
                first   = waited;
                start_t = tick;
            end
            if (bus.pmem_resp) begin
                got    = 1'b1;
                resp_t = tick;
            end
        end
        check("resp_seen", 256'(got), 256'(1));
        check("burst_start_latency", 256'(first), 256'(1));
        if (chk_lat) check("resp_latency", 256'(waited), 256'(5));
        @(posedge clk); #1;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rt, st, rt_w, st_r, sel;
        logic [31:0] a;
        logic [255:0] w;
        bus.pmem_address = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_wdata   = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", 256'(bus.mem_read), 256'(0));
        check("rst_mem_write", 256'(bus.mem_write), 256'(0));
        check("rst_pmem_resp", 256'(bus.pmem_resp), 256'(0));
        check("rst_mem_address", 256'(bus.mem_address), 256'(0));
        check("rst_mem_wdata", 256'(bus.mem_wdata), 256'(0));
        check("rst_pmem_rdata", bus.pmem_rdata, 256'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Read with back-to-back beats AA..DD at an unaligned address.
        for (int k = 0; k < 4; k++) begin
            w[63:0] = 64'hAA + 64'(k * 17);
            ref_mem[32'h1234_5660 + 32'(8 * k)]  = w[63:0];
            resp_mem[32'h1234_5660 + 32'(8 * k)] = w[63:0];
        end
        resp_pct = 100;
        do_txn(1'b0, 1'b1, 32'h1234_5678, '0, 1'b1, rt, st);
        check("directed_read_line", last_rd, {64'hDD, 64'hCC, 64'hBB, 64'hAA});

        // Write with an acknowledge only every third cycle.
        resp_period = 3;
        do_txn(1'b1, 1'b0, 32'h0000_2000, {64'h4, 64'h3, 64'h2, 64'h1}, 1'b0, rt, st);
        resp_period = 0;

        // Simultaneous requests: write wins, then read it back.
        resp_pct = 60;
        w = rand_line();
        do_txn(1'b1, 1'b1, 32'h0000_3004, w, 1'b0, rt, st);
        do_txn(1'b0, 1'b1, 32'h0000_3010, '0, 1'b0, rt, st);
        check("simul_readback", last_rd, w);
        do_txn(1'b0, 1'b1, 32'h0000_2000, '0, 1'b0, rt, st);
        check("stall_write_readback", last_rd, {64'h4, 64'h3, 64'h2, 64'h1});

        // Stray acknowledges while idle.
        stray_pct = 50;
        repeat (20) @(posedge clk);
        #1;
        stray_pct = 0;

        // Reset after two beats of a read, then a fresh read to 0x40.
        resp_pct = 100;
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.addr = 32'h0000_5000;
            b.wr = 1'b0;
            b.wdata = '0;
            beat_q.push_back(b);
        end
        bus.pmem_address = 32'h0000_5000;
        bus.pmem_read    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b0;
        held_rd = '0;
        last_rd = '0;
        n_rd = 0;
        n_wr = 0;
        beat_q.delete();
        resp_beat = 0;
        bus.pmem_read = 1'b0;
        #1;
        check("abort_mem_read", 256'(bus.mem_read), 256'(0));
        check("abort_mem_write", 256'(bus.mem_write), 256'(0));
        check("abort_pmem_resp", 256'(bus.pmem_resp), 256'(0));
        check("abort_mem_address", 256'(bus.mem_address), 256'(0));
        check("abort_pmem_rdata", bus.pmem_rdata, 256'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 1'b1, 32'h0000_0040, '0, 1'b1, rt, st);

        // Back-to-back write then read: one idle cycle between bursts.
        w = rand_line();
        do_txn(1'b1, 1'b0, 32'h0000_6000, w, 1'b1, rt_w, st);
        do_txn(1'b0, 1'b1, 32'h0000_6000, '0, 1'b1, rt, st_r);
        check("b2b_gap", 256'(st_r - rt_w), 256'(2));
        check("b2b_readback", last_rd, w);

        // Randomised traffic over a small set of lines.
        stray_pct = 20;
        for (int i = 0; i < 40; i++) begin
            resp_pct = $urandom_range(25, 100);
            sel = $urandom_range(0, 2);
            a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 8) | 32'($urandom_range(0, 31));
            w = rand_line();
            do_txn(sel != 0, sel != 1, a, w, 1'b0, rt, st);
        end
        stray_pct = 0;
        repeat (4) @(posedge clk);
        #1;
        check("exp_q_drained", 256'(exp_q.size()), 256'(0));
        check("beat_q_drained", 256'(beat_q.size()), 256'(0));
`ifdef PMEM_ADAPTOR_PERF_CNT_EN
        check("perf_reads", 256'(perf_reads), 256'(n_rd));
        check("perf_writes", 256'(perf_writes), 256'(n_wr));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
